la_capture_core: RTL and testbench
==================================

Name: la_capture_core

Overview:
- Parametrised on-chip logic-analyser capture engine; successor to the fixed 8-bit camera-data probe.
- Samples a DATA_W-bit probe bus (e.g. cmos cam_data) into a circular buffer of DEPTH entries on sys_clk.
- Trigger features: mask/value trigger with level or edge modes, occurrence counting and a programmable pre-trigger window.
- Captured window is streamed out oldest-first over a valid/ready port to the debug/UART readout logic.

Parameters:
DATA_W, 8, probe bus width (1..64)
DEPTH, 1024, buffer entries; power of two, >=4
AW, log2(DEPTH), buffer address width (derived, not overridden)

Ports:
sys_clk  in  1  capture and readout clock
sys_rst  in  1  asynchronous active-high reset
arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE
abort  in  1  forces IDLE from any state; buffer contents are discarded
sample_en  in  1  sample qualifier; probe is written only when 1 (decimation)
data_i  in  DATA_W  probe bus
trig_value  in  DATA_W  compare value
trig_mask  in  DATA_W  1 = bit participates in compare
trig_mode  in  2  00 level match, 01 match rising, 10 match falling, 11 immediate
trig_count  in  8  qualified trigger events required (0 treated as 1)
pre_cnt  in  AW  pre-trigger samples; clamped to DEPTH-1
busy  out  1  high in PRE, WAIT, POST
triggered  out  1  trigger accepted for current capture
done  out  1  capture complete, buffer readable
state_o  out  3  FSM state encoding, for debug
rd_valid  out  1  readout data valid
rd_data  out  DATA_W  readout sample
rd_last  out  1  final sample of the window
rd_ready  in  1  consumer accept

Behaviour:
- Reset: all outputs 0; FSM=IDLE; pointers, counters and the match-history register are 0. Buffer RAM is not cleared.
- FSM states: IDLE(0), PRE(1), WAIT(2), POST(3), DONE(4), READ(5).
- Configuration (trig_*, pre_cnt) is latched on the arm cycle; later changes do not affect that capture.
- "Sample cycle" = sample_en=1 in PRE, WAIT or POST. Each sample cycle writes data_i to wptr, then wptr increments mod DEPTH.
- match = ((data_i ^ trig_value) & trig_mask) == 0. All-zero mask gives constant match.
- Qualified event, evaluated on sample cycles only:
  - level mode: match.
  - rise mode: match & !prev_match.
  - fall mode: !match & prev_match.
  - prev_match updates on sample cycles only and is cleared on arm.
- IDLE/DONE + arm -> PRE. Arm also clears done, triggered and the event counter.
- PRE: count samples. After pre_cnt samples -> WAIT. With pre_cnt=0, go straight to WAIT in the cycle after arm. Events are ignored in PRE.
- WAIT: buffer wraps freely.
  - On the trig_count-th event, that sample is written, trig_ptr <= wptr, triggered <= 1, and the FSM goes to POST.
  - immediate mode triggers on the first sample cycle in WAIT.
- POST: capture DEPTH-1-pre_cnt further samples (the trigger sample is included in the total), then -> DONE with done=1.
  - Total window = DEPTH samples; the trigger sample sits at readout index pre_cnt.
- DONE + rd_ready=1 -> READ; rptr <= trig_ptr - pre_cnt (mod DEPTH).
- READ:
  - 1-cycle RAM latency; output register holds rd_valid/rd_data until rd_valid & rd_ready.
  - Exactly DEPTH beats. rd_last=1 on beat DEPTH-1.
  - Pointer wraps mod DEPTH.
  - After the last accepted beat -> DONE (done stays 1). The window can be re-read.
- Arm while busy or in READ: ignored.
- Abort has priority over arm and over trigger in the same cycle: -> IDLE, busy/done/triggered/rd_valid cleared within 1 cycle.
- Trigger and transition to WAIT in the same cycle: impossible by construction, since events are checked in WAIT only.
- Asserting sys_rst mid-capture or mid-readout: immediate return to reset values.
- Event counter saturates at 255.

Test Plan:
- DATA_W=8, DEPTH=16, pre_cnt=4, level, mask=FF, value=0x2A; ramp 0x00,0x01,... with sample_en=1 -> triggered on 0x2A; readout 16 beats 0x26..0x35; rd_last on 0x35.
- Rise mode, trig_count=3, value=0x01, mask=01, toggling LSB -> trigger on the 3rd rising LSB; the 2 earlier edges are ignored.
- Immediate mode, pre_cnt=0, sample_en high every other cycle -> done after 16 qualified samples (~32 cycles); readout equals the 16 sampled values in order.
- Readout with rd_ready toggling 1/0 each cycle -> rd_data stable while stalled; no beats lost or duplicated; 16 beats total.
- Abort asserted in POST together with a match -> state_o=0 next cycle; busy=0, done=0; a subsequent arm restarts cleanly.
- sys_rst pulsed mid-READ -> all outputs 0 asynchronously; arm is ignored while reset is held.

Source files
------------

// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture engine. Samples a probe bus into a circular buffer,
// triggers on a mask/value match (level/edge/immediate, with occurrence count) and streams the window out oldest-first.
`timescale 1ns/1ps
module la_capture_core #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 1024,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              arm,
   input  logic              abort,
   input  logic              sample_en,
   input  logic [DATA_W-1:0] data_i,
   input  logic [DATA_W-1:0] trig_value,
   input  logic [DATA_W-1:0] trig_mask,
   input  logic [1:0]        trig_mode,
   input  logic [7:0]        trig_count,
   input  logic [AW-1:0]     pre_cnt,
   output logic              busy,
   output logic              triggered,
   output logic              done,
   output logic [2:0]        state_o,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4,
      S_READ = 3'd5
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [AW:0]   ISS_END  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ISS_LAST = (AW+1)'(DEPTH - 1);

   state_t            state_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] val_q, mask_q;
   logic [1:0]        mode_q;
   logic [7:0]        tcnt_q, evt_q;
   logic [AW-1:0]     pre_q, wptr_q, rptr_q, trig_ptr_q, cnt_q;
   logic [AW:0]       iss_q;
   logic              prev_q, busy_q, trig_q, done_q, rd_valid_q, rd_last_q;

   logic              sampling, match, evt_hit, trig_fire, rd_en, rd_accept;
   logic [7:0]        evt_inc, tcnt_eff;
   logic [AW-1:0]     cnt_inc, post_target;

   assign sampling  = sample_en && (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST);
   assign rd_en     = (state_q == S_READ) && (iss_q != ISS_END) && (!rd_valid_q || rd_ready);
   assign rd_accept = rd_valid_q && rd_ready;
   assign cnt_inc     = cnt_q + AW'(1);
   assign post_target = LAST_IDX - pre_q;
   assign tcnt_eff    = (tcnt_q == 8'd0) ? 8'd1 : tcnt_q;

   always_comb begin
      match     = (((data_i ^ val_q) & mask_q) == '0);
      evt_hit   = 1'b0;
      case (mode_q)
         2'b00:   evt_hit = match;
         2'b01:   evt_hit = match & ~prev_q;
         2'b10:   evt_hit = ~match & prev_q;
         default: evt_hit = 1'b1;
      endcase
      evt_inc   = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
      trig_fire = (mode_q == 2'b11) || (evt_hit && (evt_inc >= tcnt_eff));
   end

   // Buffer RAM: one write port for capture, one registered read port for readout.
   always_ff @(posedge sys_clk) begin
      if (sampling)
         mem[wptr_q] <= data_i;
      if (rd_en)
         ram_q <= mem[rptr_q];
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= S_IDLE;
         val_q      <= '0;
         mask_q     <= '0;
         mode_q     <= '0;
         tcnt_q     <= '0;
         evt_q      <= '0;
         pre_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         trig_ptr_q <= '0;
         cnt_q      <= '0;
         iss_q      <= '0;
         prev_q     <= 1'b0;
         busy_q     <= 1'b0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else if (abort) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         if (sampling) begin
            wptr_q <= wptr_q + AW'(1);
            prev_q <= match;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  val_q   <= trig_value;
                  mask_q  <= trig_mask;
                  mode_q  <= trig_mode;
                  tcnt_q  <= trig_count;
                  pre_q   <= pre_cnt;
                  evt_q   <= '0;
                  cnt_q   <= '0;
                  prev_q  <= 1'b0;
                  trig_q  <= 1'b0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= (pre_cnt == '0) ? S_WAIT : S_PRE;
               end else if (state_q == S_DONE && rd_ready) begin
                  rptr_q  <= trig_ptr_q - pre_q;
                  iss_q   <= '0;
                  state_q <= S_READ;
               end
            end
            S_PRE: begin
               if (sampling) begin
                  if (cnt_inc == pre_q) begin
                     cnt_q   <= '0;
                     state_q <= S_WAIT;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            S_WAIT: begin
               if (sampling) begin
                  if (evt_hit)
                     evt_q <= evt_inc;
                  if (trig_fire) begin
                     trig_ptr_q <= wptr_q;
                     trig_q     <= 1'b1;
                     cnt_q      <= '0;
                     // A full pre-trigger window leaves no post samples to take.
                     if (pre_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        state_q <= S_POST;
                     end
                  end
               end
            end
            S_POST: begin
               if (sampling) begin
                  if (cnt_inc == post_target) begin
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            S_READ: begin
               if (rd_en) begin
                  rptr_q     <= rptr_q + AW'(1);
                  iss_q      <= iss_q + (AW+1)'(1);
                  rd_valid_q <= 1'b1;
                  rd_last_q  <= (iss_q == ISS_LAST);
               end else if (rd_accept) begin
                  rd_valid_q <= 1'b0;
                  rd_last_q  <= 1'b0;
                  if (rd_last_q)
                     state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign triggered = trig_q;
   assign done      = done_q;
   assign state_o   = state_q;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   // The RAM output register has no reset; gate it so rd_data reads 0 when nothing is offered.
   assign rd_data   = rd_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core (DATA_W=8, DEPTH=16): directed and randomized captures checked against
// a sample-list model of the trigger rules and the captured window.
`timescale 1ns/1ps
module tb_la_capture_core;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int AW = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          arm = 1'b0, abort = 1'b0, sample_en = 1'b0, rd_ready = 1'b0;
   logic [DW-1:0] data_i = '0, trig_value = '0, trig_mask = '0;
   logic [1:0]    trig_mode = '0;
   logic [7:0]    trig_count = '0;
   logic [AW-1:0] pre_cnt = '0;
   logic          busy, triggered, done, rd_valid, rd_last;
   logic [2:0]    state_o;
   logic [DW-1:0] rd_data;

   la_capture_core #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(arm), .abort(abort), .sample_en(sample_en),
      .data_i(data_i), .trig_value(trig_value), .trig_mask(trig_mask), .trig_mode(trig_mode),
      .trig_count(trig_count), .pre_cnt(pre_cnt), .busy(busy), .triggered(triggered), .done(done),
      .state_o(state_o), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors = 0;
   int errs = 0;

   // Model: the list of samples taken since arm, and where the trigger fell in it.
   logic [DW-1:0] samp[$];
   logic [DW-1:0] m_val, m_mask;
   int            m_mode, m_cnt, m_pre, m_evt, m_tidx;
   bit            m_trig, m_done;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_match(input logic [DW-1:0] d);
      return ((d ^ m_val) & m_mask) == '0;
   endfunction

   task automatic model_push(input logic [DW-1:0] d);
      int idx;
      bit cur, prv, ev;
      idx = samp.size();
      samp.push_back(d);
      cur = m_match(d);
      prv = (idx == 0) ? 1'b0 : m_match(samp[idx-1]);
      if (!m_trig && idx >= m_pre) begin
         case (m_mode)
            0: ev = cur;
            1: ev = cur && !prv;
            2: ev = !cur && prv;
            default: ev = 1'b1;
         endcase
         if (ev) begin
            m_evt++;
            if (m_mode == 3 || m_evt >= ((m_cnt == 0) ? 1 : m_cnt)) begin
               m_trig = 1'b1;
               m_tidx = idx;
            end
         end
      end
      if (m_trig && idx == m_tidx + DEPTH - 1 - m_pre)
         m_done = 1'b1;
   endtask

   task automatic do_arm(input int mode, input logic [DW-1:0] val, input logic [DW-1:0] mask,
                         input int cnt, input int pre);
      trig_mode = 2'(mode); trig_value = val; trig_mask = mask;
      trig_count = 8'(cnt); pre_cnt = AW'(pre); sample_en = 1'b0; arm = 1'b1;
      m_mode = mode; m_val = val; m_mask = mask; m_cnt = cnt; m_pre = pre;
      m_evt = 0; m_tidx = 0; m_trig = 1'b0; m_done = 1'b0;
      samp.delete();
      step();
      arm = 1'b0;
      // Scramble the live config so that only the latched copy can produce the right result.
      trig_value = ~val; trig_mask = 8'hFF; trig_mode = 2'(mode) ^ 2'b01;
      trig_count = 8'(cnt + 7); pre_cnt = ~AW'(pre);
      check("arm_busy", busy, 1);
      check("arm_state", state_o, (pre == 0) ? 2 : 1);
      check("arm_done", done, 0);
      check("arm_trig", triggered, 0);
   endtask

   // dpat: 0 ramp, 1 toggling LSB with random upper bits, 2 random. sepat: 0 always, 1 every other, 2 random.
   task automatic run_capture(input int dpat, input int sepat, input int post_limit);
      int k = 0;
      int after = 0;
      logic se;
      logic [DW-1:0] d;
      while (!m_done && k < 3000 && !(post_limit >= 0 && m_trig && after >= post_limit)) begin
         se = (sepat == 0) ? 1'b1 : (sepat == 1) ? 1'(k % 2) : ($urandom_range(0, 3) != 0);
         d  = (dpat == 0) ? DW'(k) : (dpat == 1) ? {7'($urandom), 1'(k % 2)} : DW'($urandom);
         sample_en = se; data_i = d;
         step();
         if (se) model_push(d);
         if (m_trig) after++;
         check("cap_busy", busy, !m_done);
         check("cap_trig", triggered, m_trig);
         check("cap_done", done, m_done);
         k++;
      end
      sample_en = 1'b0;
      if (k >= 3000) begin
         errs++;
         $error("FAIL cap_timeout: observed no completion expected done within 3000 cycles");
      end
      if (m_done) check("cap_state", state_o, 4);
   endtask

   task automatic readout(input bit toggle);
      int beat = 0;
      int cyc = 0;
      bit rdy;
      logic [DW-1:0] expv;
      while (beat < DEPTH && cyc < 300) begin
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         rd_ready = rdy;
         if (rd_valid === 1'b1) begin
            expv = samp[m_tidx - m_pre + beat];
            check(rdy ? "rd_data" : "rd_hold", rd_data, expv);
            check("rd_last", rd_last, (beat == DEPTH - 1));
            if (rdy) beat++;
         end
         step();
         cyc++;
      end
      rd_ready = 1'b0;
      if (beat < DEPTH) begin
         errs++;
         $error("FAIL rd_timeout: observed %0d beats expected %0d", beat, DEPTH);
      end
      check("rd_end_valid", rd_valid, 0);
      check("rd_end_state", state_o, 4);
      check("rd_end_done", done, 1);
      step();
      check("rd_no_extra", rd_valid, 0);
   endtask

   initial begin
      step(); step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_trig", triggered, 0);
      check("rst_state", state_o, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_data", rd_data, 0);
      check("rst_last", rd_last, 0);
      sys_rst = 1'b0;
      step();

      // Level trigger on a ramp, read twice (second time with a stalling consumer).
      do_arm(0, 8'h2A, 8'hFF, 1, 4);
      run_capture(0, 0, -1);
      readout(1'b0);
      readout(1'b1);

      // Third rising edge of the LSB.
      do_arm(1, 8'h01, 8'h01, 3, 2);
      run_capture(1, 0, -1);
      readout(1'b0);

      // Immediate trigger, no pre-window, decimated sampling.
      do_arm(3, DW'($urandom), DW'($urandom), 0, 0);
      run_capture(2, 1, -1);
      readout(1'b1);

      // Randomized configurations; pre may reach DEPTH-1.
      for (int i = 0; i < 4; i++) begin
         do_arm($urandom_range(0, 2), DW'($urandom), DW'($urandom_range(1, 3)),
                $urandom_range(0, 4), (i == 3) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1));
         run_capture(2, 2, -1);
         readout(1'(i % 2));
      end

      // Abort in POST with a constant match and a simultaneous arm.
      do_arm(0, 8'h00, 8'h00, 1, 2);
      run_capture(2, 0, 3);
      check("pre_abort_state", state_o, 3);
      abort = 1'b1; arm = 1'b1; sample_en = 1'b1; data_i = 8'h00;
      step();
      abort = 1'b0; arm = 1'b0; sample_en = 1'b0;
      check("abort_state", state_o, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_trig", triggered, 0);
      check("abort_valid", rd_valid, 0);
      do_arm(2, DW'($urandom), 8'h01, 2, 5);
      run_capture(2, 2, -1);
      readout(1'b0);

      // Reset pulsed in the middle of a readout.
      do_arm(0, DW'($urandom), 8'h03, 1, 7);
      run_capture(2, 0, -1);
      rd_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      #2 sys_rst = 1'b1;
      #1;
      check("mid_rst_state", state_o, 0);
      check("mid_rst_valid", rd_valid, 0);
      check("mid_rst_data", rd_data, 0);
      check("mid_rst_last", rd_last, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_trig", triggered, 0);
      check("mid_rst_busy", busy, 0);
      rd_ready = 1'b0;
      arm = 1'b1;
      step();
      check("rst_arm_state", state_o, 0);
      check("rst_arm_busy", busy, 0);
      arm = 1'b0;
      sys_rst = 1'b0;
      step();
      check("post_rst_state", state_o, 0);
      do_arm(1, DW'($urandom), 8'h02, 1, 3);
      run_capture(2, 2, -1);
      readout(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
